// File: rtl/amp_mod_pkg.sv
// Shared types and constants for the amp_modulator scheduler slice.
// Scheduler state encoding and the Q8 gain shift used by amp_modulator.
package amp_mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // Gain is Q8: product is shifted right by this amount inside amp_modulator.
    localparam int AMP_Q8_SHIFT = 8;

endpackage

// File: rtl/amp_mod_dp_if.sv
// Operand/result bus between the scheduler (master) and the single amp_modulator (slave).
interface amp_mod_dp_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] dp_signal;
    logic [DATA_WIDTH-1:0] dp_modulator;
    logic [DATA_WIDTH-1:0] dp_result;

    modport master (output dp_signal, output dp_modulator, input dp_result);
    modport slave  (input dp_signal, input dp_modulator, output dp_result);
endinterface

// File: rtl/amp_mod_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping at NUM_CH-1.
module amp_mod_rr_pick #(
    parameter int NUM_CH = 4,
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CW-1:0]     idx_o,
    output logic              any_o
);
    int            j;
    logic [CW-1:0] sel;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        sel   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            sel = CW'(j);
            if (!any_o && req_i[sel]) begin
                any_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end
endmodule

// File: rtl/amp_mod_scheduler.sv
// Time-shares one amp_modulator datapath among NUM_CH voices; results return tagged by channel.
// Define AMP_MOD_SCHED_PRIORITY_EN to give ch0 strict priority over the round-robin channels.
module amp_mod_scheduler
    import amp_mod_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DP_LATENCY = 2,
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] signal_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] modulator_i,
    output logic [NUM_CH-1:0]            gnt_o,
    amp_mod_dp_if.master                 dp,
    output logic [DATA_WIDTH-1:0]        result_o,
    output logic [CW-1:0]                result_ch_o,
    output logic                         result_valid_o,
    output logic                         busy_o,
    output sched_state_e                 state_o
);
    typedef struct packed {
        logic          valid;
        logic [CW-1:0] ch;
    } tag_t;

    sched_state_e          state_q, state_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] dp_sig_q, dp_sig_d, dp_mod_q, dp_mod_d;
    tag_t                  tag_q [DP_LATENCY+1];
    tag_t                  tag_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic [CW-1:0]         result_ch_q;
    logic                  result_valid_q;
    logic [NUM_CH-1:0]     pick_gnt, gnt;
    logic [CW-1:0]         pick_idx, gnt_idx;
    logic                  pick_any, grant_en, tags_busy;

    amp_mod_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grants only in RUN with enable still high; a priority win leaves the rr pointer alone.
    always_comb begin
        grant_en = (state_q == RUN) && enable_i && !rst_i;
        gnt      = '0;
        gnt_idx  = '0;
        ptr_d    = ptr_q;
`ifdef AMP_MOD_SCHED_PRIORITY_EN
        if (grant_en && req_i[0]) begin
            gnt[0] = 1'b1;
        end else
`endif
        if (grant_en && pick_any) begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
            ptr_d   = (pick_idx == CW'(NUM_CH - 1)) ? '0 : pick_idx + CW'(1);
        end
    end

    always_comb begin
        dp_sig_d    = dp_sig_q;
        dp_mod_d    = dp_mod_q;
        tag_d.valid = |gnt;
        tag_d.ch    = gnt_idx;
        if (|gnt) begin
            dp_sig_d = signal_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            dp_mod_d = modulator_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i <= DP_LATENCY; i++) tags_busy = tags_busy | tag_q[i].valid;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i) state_d = DRAIN;
            DRAIN:   if (enable_i) state_d = RUN;
                     else if (!tags_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Last tag stage lines up with dp_result, so the result regs sample both together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            dp_sig_q       <= '0;
            dp_mod_q       <= '0;
            for (int i = 0; i <= DP_LATENCY; i++) tag_q[i] <= '0;
            result_q       <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            dp_sig_q       <= dp_sig_d;
            dp_mod_q       <= dp_mod_d;
            tag_q[0]       <= tag_d;
            for (int i = 1; i <= DP_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            result_valid_q <= tag_q[DP_LATENCY].valid;
            if (tag_q[DP_LATENCY].valid) begin
                result_q    <= dp.dp_result;
                result_ch_q <= tag_q[DP_LATENCY].ch;
            end
        end
    end

    assign gnt_o           = gnt;
    assign dp.dp_signal    = dp_sig_q;
    assign dp.dp_modulator = dp_mod_q;
    assign result_o        = result_q;
    assign result_ch_o     = result_ch_q;
    assign result_valid_o  = result_valid_q;
    assign busy_o          = (state_q != IDLE);
    assign state_o         = state_q;
endmodule

// File: tb/tb_amp_mod_scheduler.sv
// Self-checking bench for amp_mod_scheduler: directed steps plus random traffic against a cycle model.
module tb_amp_mod_scheduler;
    import amp_mod_pkg::*;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int DPL = 2;
    localparam int CW  = 2;

    typedef struct {
        int            due;
        logic [CW-1:0] ch;
        logic [DW-1:0] val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [NCH-1:0]     req = '0;
    logic [NCH*DW-1:0]  sig = '0;
    logic [NCH*DW-1:0]  modv = '0;
    logic [NCH-1:0]     gnt;
    logic [DW-1:0]      result;
    logic [CW-1:0]      result_ch;
    logic               result_valid;
    logic               busy;
    sched_state_e       state;

    amp_mod_dp_if #(.DATA_WIDTH(DW)) dp_bus ();

    amp_mod_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DP_LATENCY(DPL)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .req_i          (req),
        .signal_i       (sig),
        .modulator_i    (modv),
        .gnt_o          (gnt),
        .dp             (dp_bus),
        .result_o       (result),
        .result_ch_o    (result_ch),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .state_o        (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- datapath stand-in: DPL-cycle delay of (s*m)>>>8 ----------------
    function automatic logic [DW-1:0] amp(input logic [DW-1:0] s, input logic [DW-1:0] m);
        logic signed [31:0] p;
        p = $signed(s) * $signed(m);
        p = p >>> AMP_Q8_SHIFT;
        return p[DW-1:0];
    endfunction

    logic [DW-1:0] pipe [DPL];
    initial for (int i = 0; i < DPL; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= amp(dp_bus.dp_signal, dp_bus.dp_modulator);
        for (int i = 1; i < DPL; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_bus.dp_result = pipe[DPL-1];

    // ---------------- scoreboard / model state ----------------
    exp_t           exp_q[$];
    int             n_assert = 0;
    int             n_fail = 0;
    int             cyc = 0;
    bit             run_m = 1'b0;
    bit             busy_m = 1'b0;
    int             ptr_m = 0;
    int             last_gnt_cyc = -100;
    logic [NCH-1:0] last_eg = '0;
    logic [NCH-1:0] snap_gnt;
    logic           snap_valid, snap_busy;
    logic [DW-1:0]  snap_res;
    logic [CW-1:0]  snap_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, compare with the model, advance the model.
    task automatic tick();
        logic [NCH-1:0] eg;
        int             ch;
        bit             prio;
        bit             ev;
        bit             nonempty;
        exp_t           e;
        @(negedge clk);
        snap_gnt   = gnt;
        snap_valid = result_valid;
        snap_busy  = busy;
        snap_res   = result;
        snap_ch    = result_ch;
        eg   = '0;
        ch   = -1;
        prio = 1'b0;
        if (run_m && enable && !rst && (req != '0)) begin
`ifdef AMP_MOD_SCHED_PRIORITY_EN
            if (req[0]) begin
                ch   = 0;
                prio = 1'b1;
            end
`endif
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (ptr_m + k) % NCH;
                if (ch < 0 && req[c]) ch = c;
            end
            eg[ch] = 1'b1;
            if (!prio) ptr_m = (ch + 1) % NCH;
            e.due = cyc + DPL + 2;
            e.ch  = CW'(ch);
            e.val = amp(sig[ch*DW +: DW], modv[ch*DW +: DW]);
            exp_q.push_back(e);
        end
        if (cyc > 0) begin
            chk("gnt", gnt, eg);
            chk("busy", busy, busy_m);
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("res_valid", result_valid, ev);
            if (ev) begin
                chk("res_val", result, exp_q[0].val);
                chk("res_ch", result_ch, exp_q[0].ch);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        nonempty = (last_gnt_cyc >= cyc - 1 - DPL);
        if (ch >= 0) last_gnt_cyc = cyc;
        if (rst) begin
            run_m = 1'b0;
            busy_m = 1'b0;
            ptr_m = 0;
            last_gnt_cyc = -100;
            while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        end else if (enable) begin
            run_m = 1'b1;
            busy_m = 1'b1;
        end else if (run_m) begin
            run_m = 1'b0;
            busy_m = 1'b1;
        end else begin
            busy_m = busy_m && nonempty;
        end
        last_eg = eg;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Requesters keep data stable while waiting; a channel may change only when idle or just served.
    task automatic drive_random();
        for (int i = 0; i < NCH; i++) begin
            if (!req[i] || last_eg[i]) begin
                req[i]            = ($urandom_range(0, 3) != 0);
                sig[i*DW +: DW]   = DW'($urandom);
                modv[i*DW +: DW]  = DW'($urandom);
            end
        end
        enable = ($urandom_range(0, 15) != 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cnt;
        logic [NCH-1:0] one;

        // Reset held with all channels requesting
        rst = 1'b1; req = '1; enable = 1'b1;
        tick();
        repeat (4) begin
            tick();
            chk("t1_gnt", snap_gnt, '0);
            chk("t1_valid", snap_valid, 1'b0);
            chk("t1_busy", snap_busy, 1'b0);
        end
        chk("t1_state", state, IDLE);

        // Single channel 2 request: 1000 * 128 / 256 = 500
        rst = 1'b0; req = '0; enable = 1'b0;
        tick();
        sig[2*DW +: DW] = 16'd1000; modv[2*DW +: DW] = 16'd128;
        req = 4'b0100; enable = 1'b1;
        tick();
        tick();
        chk("t2_gnt", snap_gnt, 4'b0100);
        req = '0;
        repeat (3) tick();
        tick();
        chk("t2_valid", snap_valid, 1'b1);
        chk("t2_res", snap_res, 16'd500);
        chk("t2_ch", snap_ch, 2);

        // All four requesting from a fresh pointer: 0,1,2,3,0,1,2,3 with no gaps
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sig[i*DW +: DW]  = DW'($urandom);
            modv[i*DW +: DW] = DW'($urandom);
        end
        req = '1;
        tick();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(snap_valid);
`ifndef AMP_MOD_SCHED_PRIORITY_EN
            one = 4'b0001 << (i % NCH);
            chk("t3_order", snap_gnt, one);
`endif
        end
        req = '0;
        repeat (4) begin
            tick();
            cnt += int'(snap_valid);
        end
        chk("t3_results", cnt, 8);

        // Enable drops with two samples in flight
        req = '1;
        tick();
        tick();
        enable = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            cnt += int'(snap_valid);
        end
        chk("t4_results", cnt, 2);
        chk("t4_busy_low", snap_busy, 1'b0);

        // Reset mid-stream with three in flight
        enable = 1'b1;
        tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0;
        cnt = 0;
        repeat (5) begin
            tick();
            cnt += int'(snap_valid);
        end
        chk("t5_no_result", cnt, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("t5_first_gnt", snap_gnt, 4'b0001);

`ifdef AMP_MOD_SCHED_PRIORITY_EN
        // ch0 strict priority, then resume at the saved pointer
        repeat (4) begin
            tick();
            chk("t6_prio", snap_gnt, 4'b0001);
        end
        req = 4'b1110;
        tick();
        chk("t6_resume1", snap_gnt, 4'b0010);
        tick();
        chk("t6_resume2", snap_gnt, 4'b0100);
`endif

        // Random traffic with occasional enable drops
        repeat (400) begin
            drive_random();
            tick();
        end
        enable = 1'b0; req = '0;
        repeat (12) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
